// File: rtl/clk_div_multi.sv
// clk_div_multi
//   Bank of NCH independent programmable clock dividers sharing one clock.
//   Each channel counts enabled cycles up to its divisor N and emits a
//   one-cycle tick every N cycles, plus a divided clock that is either a
//   50% square wave of period 2N (mode 0) or a copy of tick (mode 1).
//
// Parameters
//   NCH      number of channels (1..16)
//   CNT_W    width of each divisor and counter
//   DEF_DIV  divisor every channel holds after reset
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        asynchronous active-high reset
//   en         global count enable (freezes counters and clk_out when low)
//   sync       synchronous restart of every channel (div/mode kept)
//   load       one-cycle write strobe for divisor and mode
//   load_ch    channel addressed by load; values >= NCH are ignored
//   load_div   new divisor N (0 turns the channel off)
//   load_mode  new mode: 0 = square wave, 1 = pulse
//   tick       registered one-cycle strobe per channel at terminal count
//   clk_out    registered divided clock per channel
module clk_div_multi #(
    parameter int          NCH     = 4,
    parameter int          CNT_W   = 32,
    parameter int unsigned DEF_DIV = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [3:0]       load_ch,
    input  logic [CNT_W-1:0] load_div,
    input  logic             load_mode,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   clk_out
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] div_q [NCH];
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [NCH-1:0]   mode_q;

    logic [NCH-1:0]   wr;    // this channel is written on this edge
    logic [NCH-1:0]   clr;   // this channel is restarted on this edge
    logic [NCH-1:0]   term;  // counter sits at N-1

    // An out-of-range load_ch never matches any index, so such writes
    // simply fall on the floor.
    always_comb begin
        wr   = '0;
        clr  = '0;
        term = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            wr[i]   = load && (32'(load_ch) == i);
            // Clearing outranks terminal count; div==0 parks the channel.
            clr[i]  = wr[i] || sync || (div_q[i] == '0);
            term[i] = (cnt_q[i] == div_q[i] - ONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                div_q[i] <= DIV_RST;
                cnt_q[i] <= '0;
            end
            mode_q  <= '0;
            tick    <= '0;
            clk_out <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (wr[i]) begin
                    div_q[i]  <= load_div;
                    mode_q[i] <= load_mode;
                end

                if (clr[i]) begin
                    cnt_q[i]   <= '0;
                    tick[i]    <= 1'b0;
                    clk_out[i] <= 1'b0;
                end else if (!en) begin
                    // Hold count and square wave; pulse-mode clk_out
                    // follows the forced-low tick.
                    tick[i] <= 1'b0;
                    if (mode_q[i]) begin
                        clk_out[i] <= 1'b0;
                    end
                end else if (term[i]) begin
                    cnt_q[i]   <= '0;
                    tick[i]    <= 1'b1;
                    clk_out[i] <= mode_q[i] ? 1'b1 : ~clk_out[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + ONE;
                    tick[i]  <= 1'b0;
                    if (mode_q[i]) begin
                        clk_out[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi
//   Directed bench for clk_div_multi (NCH=4, CNT_W=16, DEF_DIV=8).
//   A phase-based model (enabled edges since last restart) predicts every
//   output each cycle; literal tick/clk_out histories pin the model.
module tb_clk_div_multi;

    localparam int NCH   = 4;
    localparam int CNT_W = 16;
    localparam int DEFD  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             sync;
    logic             load;
    logic [3:0]       load_ch;
    logic [CNT_W-1:0] load_div;
    logic             load_mode;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   clk_out;

    int checks = 0;
    int errors = 0;

    // Model: divisor, mode, phase = enabled edges since last restart.
    int unsigned m_div  [NCH];
    int unsigned m_ph   [NCH];
    bit          m_mode [NCH];
    bit          m_tk   [NCH];

    bit [15:0] h0, h1, h2, h3, c0, c2;
    bit        acc;

    clk_div_multi #(
        .NCH     (NCH),
        .CNT_W   (CNT_W),
        .DEF_DIV (DEFD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync      (sync),
        .load      (load),
        .load_ch   (load_ch),
        .load_div  (load_div),
        .load_mode (load_mode),
        .tick      (tick),
        .clk_out   (clk_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_div[c]  = DEFD;
            m_mode[c] = 1'b0;
            m_ph[c]   = 0;
            m_tk[c]   = 1'b0;
        end
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            bit hit;
            hit = load && (int'(load_ch) == c);
            if (hit) begin
                m_div[c]  = load_div;
                m_mode[c] = load_mode;
            end
            if (hit || sync || m_div[c] == 0) begin
                m_ph[c] = 0;
                m_tk[c] = 1'b0;
            end else if (en) begin
                m_ph[c] = m_ph[c] + 1;
                m_tk[c] = (m_ph[c] % m_div[c]) == 0;
            end else begin
                m_tk[c] = 1'b0;
            end
        end
    endtask

    function automatic bit model_clk(input int c);
        if (m_mode[c]) return m_tk[c];
        if (m_div[c] == 0) return 1'b0;
        return ((m_ph[c] / m_div[c]) % 2) == 1;
    endfunction

    // One clock: update model with the inputs the DUT sampled, compare all
    // channels, then drop the one-cycle strobes.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("model_tick[%0d]", c), tick[c], m_tk[c]);
            check($sformatf("model_clk_out[%0d]", c), clk_out[c], model_clk(c));
        end
        load = 1'b0;
        sync = 1'b0;
    endtask

    task automatic do_load(input int ch, input int dv, input bit md);
        load      = 1'b1;
        load_ch   = 4'(ch);
        load_div  = CNT_W'(dv);
        load_mode = md;
        cyc();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sync = 1'b0; load = 1'b0;
        load_ch = '0; load_div = '0; load_mode = 1'b0;
        model_reset();
        #12;
        check("reset_tick", tick, 0);
        check("reset_clk_out", clk_out, 0);
        rst = 1'b0;

        // Program ch0 N=5 sq, ch1 N=3 pulse, ch2 N=1 sq while disabled.
        do_load(0, 5, 1'b0);
        do_load(1, 3, 1'b1);
        do_load(2, 1, 1'b0);
        en = 1'b1;
        h0 = '0; h1 = '0; c0 = '0; c2 = '0;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            h0[k] = tick[0];
            c0[k] = clk_out[0];
            h1[k] = tick[1] & clk_out[1];
            c2[k] = clk_out[2];
        end
        check("ch0_tick_5_10_15", h0, 16'h8420);
        check("ch0_clk_out_period10", c0, 16'h83E0);
        check("ch1_pulse_every3", h1, 16'h9248);
        check("ch2_toggle_every", c2, 16'hAAAA);

        // Freeze at cnt=2 for 7 cycles, then tick on third enabled edge.
        cyc(); cyc();
        en = 1'b0;
        acc = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            acc |= tick[0];
        end
        check("hold_no_tick", acc, 0);
        check("hold_clk_out_frozen", clk_out[0], 1);
        en = 1'b1;
        h0 = '0;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            h0[k] = tick[0];
        end
        check("resume_tick_third", h0, 16'h0008);
        check("resume_clk_out", clk_out[0], 0);

        // sync on ch0's terminal edge together with a load to ch3 N=2.
        cyc(); cyc(); cyc(); cyc();
        sync = 1'b1;
        do_load(3, 2, 1'b0);
        check("sync_suppress_tick", tick[0], 0);
        check("sync_clk_out", clk_out[0], 0);
        h0 = '0; h3 = '0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            h0[k] = tick[0];
            h3[k] = tick[3];
        end
        check("sync_next_tick_5", h0, 16'h0020);
        check("ch3_loaded_n2", h3, 16'h0014);

        // Out-of-range write ignored; then ch0 turned off.
        do_load(7, 1, 1'b1);
        for (int k = 0; k < 4; k++) cyc();
        do_load(0, 0, 1'b0);
        acc = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            acc |= tick[0] | clk_out[0];
        end
        check("ch0_off_quiet", acc, 0);

        // Asynchronous reset mid-period.
        cyc();
        check("pre_rst_ch2_tick", tick[2], 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_tick", tick, 0);
        check("async_rst_clk_out", clk_out, 0);
        model_reset();
        cyc(); cyc();
        rst = 1'b0;
        h0 = '0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            h0[k] = tick[0];
        end
        check("post_rst_def_div", h0, 16'h0100);
        check("post_rst_all_tick", tick, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
